// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit FND scan controller.
// Holds segment codes, widths, the conversion FSM encoding and BCD helpers.
package fnd_pkg;

  localparam int NUM_DIGITS   = 4;
  localparam int BCD_W        = 16;
  localparam int BIN_W        = 14;
  localparam int SHIFT_CYCLES = 14;

  localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) begin
        res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end else begin
        res[4*n +: 4] = bcd[4*n +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 16-bit BCD converter (double-dabble).
// start is taken only in IDLE; busy covers LOAD, SHIFT and DONE; done marks the result cycle.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             ovf_o
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Out-of-range inputs display as 9999 with the overflow flag set
        ovf_d   = (bin_i > MAX_VAL);
        bin_d   = (bin_i > MAX_VAL) ? MAX_VAL : bin_i;
        bcd_d   = '0;
        cnt_d   = 4'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d = {dabble_adjust(bcd_q)[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == ST_DONE);
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed 4-digit 7-segment scan controller with leading-zero blanking.
// Each scan tick registers the next digit; a new BCD conversion starts after digit 3.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter logic       BLANK_LEADING = 1'b1,
  parameter logic [3:0] DP_MASK       = 4'b0000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_fnd,
  input  logic [BIN_W-1:0]      i_value,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [7:0]            o_seg,
  output logic                  o_busy,
  output logic                  o_ovf
);

  logic                  sync1_q, sync2_q, hist_q;
  logic                  scan_tick_s;
  logic [1:0]            idx_q, idx_d;
  logic                  shown_q;
  logic                  init_q;
  logic [NUM_DIGITS-1:0] an_q, an_s;
  logic [7:0]            seg_q, seg_s;
  logic [BCD_W-1:0]      bcd_disp_q;
  logic                  ovf_q;
  logic                  start_s;
  logic                  conv_done_s;
  logic                  conv_busy_s;
  logic                  conv_ovf_s;
  logic [BCD_W-1:0]      conv_bcd_s;
  logic [3:1]            lz_s;
  logic [3:0]            digit_s;
  logic                  blank_s;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= i_clk_fnd;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign scan_tick_s = sync2_q & ~hist_q;

  // The first tick after reset shows digit 0 without advancing the index
  always_comb begin
    idx_d   = idx_q;
    start_s = init_q;
    if (scan_tick_s && shown_q) begin
      idx_d   = idx_q + 2'd1;
      start_s = init_q | (idx_q == 2'd3);
    end else begin
      idx_d   = idx_q;
      start_s = init_q;
    end
  end

  always_comb begin
    lz_s[3] = (bcd_disp_q[15:12] == 4'd0);
    lz_s[2] = lz_s[3] & (bcd_disp_q[11:8] == 4'd0);
    lz_s[1] = lz_s[2] & (bcd_disp_q[7:4] == 4'd0);
    digit_s = bcd_disp_q[3:0];
    blank_s = 1'b0;
    an_s    = 4'b1110;
    case (idx_d)
      2'd0: begin digit_s = bcd_disp_q[3:0];   blank_s = 1'b0;    an_s = 4'b1110; end
      2'd1: begin digit_s = bcd_disp_q[7:4];   blank_s = lz_s[1]; an_s = 4'b1101; end
      2'd2: begin digit_s = bcd_disp_q[11:8];  blank_s = lz_s[2]; an_s = 4'b1011; end
      2'd3: begin digit_s = bcd_disp_q[15:12]; blank_s = lz_s[3]; an_s = 4'b0111; end
      default: begin digit_s = 4'd0; blank_s = 1'b0; an_s = 4'b1111; end
    endcase
    if (BLANK_LEADING && blank_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_encode(digit_s);
    end
    seg_s = seg_s & ~{DP_MASK[idx_d], 7'b0000000};
  end

  // Display registers change only on a scan tick, so conversions never show mid-digit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_q   <= 2'd0;
      shown_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      init_q  <= 1'b1;
    end else begin
      init_q <= 1'b0;
      if (scan_tick_s) begin
        idx_q   <= idx_d;
        shown_q <= 1'b1;
        an_q    <= an_s;
        seg_q   <= seg_s;
      end else begin
        idx_q   <= idx_q;
        shown_q <= shown_q;
        an_q    <= an_q;
        seg_q   <= seg_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bcd_disp_q <= '0;
      ovf_q      <= 1'b0;
    end else if (conv_done_s) begin
      bcd_disp_q <= conv_bcd_s;
      ovf_q      <= conv_ovf_s;
    end else begin
      bcd_disp_q <= bcd_disp_q;
      ovf_q      <= ovf_q;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .start_i (start_s),
    .bin_i   (i_value),
    .busy_o  (conv_busy_s),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s),
    .ovf_o   (conv_ovf_s)
  );

  assign o_an   = an_q;
  assign o_seg  = seg_q;
  assign o_busy = conv_busy_s;
  assign o_ovf  = ovf_q;

endmodule
